fib_seq_gen: RTL and testbench

Parametrised Fibonacci-style sequence generator. Given seeds S0/S1 and a term count N, it streams N terms over a valid/ready output, tagging each term with its index and a last flag. It adds configurable width, wrap or saturating arithmetic, per-term and sticky overflow reporting, and back-pressure. It serves as a reusable stimulus/sequence source feeding downstream streaming blocks in the w-series designs.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_step_add.sv | 32 +++
 rtl/fib_seq_gen.sv | 129 ++++++++++++
 tb/tb_fib_seq_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci-style sequence generator.
package fib_pkg;

    // Two-state controller: waiting for a start, or streaming terms.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fib_state_t;

    // Arithmetic mode selectors for the SAT_MODE parameter.
    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

endpackage

// File: rtl/fib_step_add.sv
// Combinational next-term adder: sum = a + b with carry-out, either wrapping
// modulo 2^WIDTH or clamping to all-ones when the add carries.
module fib_step_add
    import fib_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] raw;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign carry = raw[WIDTH];

    // Per-bit result select: saturation forces every bit high on carry.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (SAT_MODE == SAT_SAT) begin : g_sat
                assign sum[gi] = raw[gi] | raw[WIDTH];
            end else begin : g_wrap
                assign sum[gi] = raw[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci-style sequence generator with valid/ready output.
// Streams n_terms terms starting from seed0/seed1, tagging each with its index,
// a last flag and a per-term overflow flag, plus a sticky run overflow.
// Optional macro FIB_SEQ_ABORT_EN adds an 'abort' input that ends a run early.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 8,
    parameter int SAT_MODE = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [CNT_W-1:0] n_terms,
`ifdef FIB_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy,
    output logic             overflow
);

    fib_state_t       state_reg;
    logic [WIDTH-1:0] a_reg;        // term currently presented
    logic [WIDTH-1:0] b_reg;        // term presented after the next handshake
    logic             a_tag_reg;
    logic             b_tag_reg;
    logic [CNT_W-1:0] rem_reg;      // terms left including the presented one
    logic [CNT_W-1:0] idx_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             ovf_sticky_reg;

    logic [WIDTH-1:0] sum_next;
    logic             carry_next;

    // Next-but-one term, computed from the current hold pair.
    fib_step_add #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_step (
        .a     (a_reg),
        .b     (b_reg),
        .sum   (sum_next),
        .carry (carry_next)
    );

    // Controller: run acceptance, handshake advance, termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            a_tag_reg      <= 1'b0;
            b_tag_reg      <= 1'b0;
            rem_reg        <= '0;
            idx_reg        <= '0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A zero-length request is dropped without touching state.
                    if (start && (n_terms != '0)) begin
                        state_reg      <= RUN;
                        a_reg          <= seed0;
                        b_reg          <= seed1;
                        a_tag_reg      <= 1'b0;
                        b_tag_reg      <= 1'b0;
                        rem_reg        <= n_terms;
                        idx_reg        <= '0;
                        valid_reg      <= 1'b1;
                        last_reg       <= (n_terms == CNT_W'(1));
                        ovf_sticky_reg <= 1'b0;
                    end
                end
                RUN: begin
`ifdef FIB_SEQ_ABORT_EN
                    if (abort) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end else
`endif
                    if (out_ready) begin
                        if (last_reg) begin
                            // Final term consumed; the hold pair is left as-is.
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            rem_reg   <= rem_reg - CNT_W'(1);
                        end else begin
                            a_reg     <= b_reg;
                            a_tag_reg <= b_tag_reg;
                            b_reg     <= sum_next;
                            b_tag_reg <= carry_next;
                            idx_reg   <= idx_reg + CNT_W'(1);
                            rem_reg   <= rem_reg - CNT_W'(1);
                            last_reg  <= (rem_reg == CNT_W'(2));
                            // Sticky flag tracks terms that actually get presented.
                            if (b_tag_reg) begin
                                ovf_sticky_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = a_reg;
    assign out_idx   = idx_reg;
    assign out_last  = last_reg;
    assign out_ovf   = a_tag_reg;
    assign busy      = (state_reg == RUN);
    assign overflow  = ovf_sticky_reg;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: three instances (32-bit wrap, 8-bit wrap,
// 8-bit saturate) share stimulus; a reference model pushes expected terms.
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed0;
    logic [31:0] seed1;
    logic [7:0]  n_terms;
    logic        out_ready;
`ifdef FIB_SEQ_ABORT_EN
    logic        abort;
`endif

    logic [2:0]       v_arr, l_arr, o_arr, b_arr, f_arr;
    logic [2:0][7:0]  i_arr;
    logic [2:0][31:0] d_arr;
    logic [31:0]      d32;
    logic [7:0]       dw, ds;

    assign d_arr[0] = d32;
    assign d_arr[1] = {24'b0, dw};
    assign d_arr[2] = {24'b0, ds};

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(32), .CNT_W(8), .SAT_MODE(0)) dut32 (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
        .n_terms(n_terms),
`ifdef FIB_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_ready(out_ready), .out_valid(v_arr[0]), .out_data(d32),
        .out_idx(i_arr[0]), .out_last(l_arr[0]), .out_ovf(o_arr[0]),
        .busy(b_arr[0]), .overflow(f_arr[0])
    );

    fib_seq_gen #(.WIDTH(8), .CNT_W(8), .SAT_MODE(0)) dut8w (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
        .n_terms(n_terms),
`ifdef FIB_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_ready(out_ready), .out_valid(v_arr[1]), .out_data(dw),
        .out_idx(i_arr[1]), .out_last(l_arr[1]), .out_ovf(o_arr[1]),
        .busy(b_arr[1]), .overflow(f_arr[1])
    );

    fib_seq_gen #(.WIDTH(8), .CNT_W(8), .SAT_MODE(1)) dut8s (
        .clk(clk), .rst(rst), .start(start), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
        .n_terms(n_terms),
`ifdef FIB_SEQ_ABORT_EN
        .abort(abort),
`endif
        .out_ready(out_ready), .out_valid(v_arr[2]), .out_data(ds),
        .out_idx(i_arr[2]), .out_last(l_arr[2]), .out_ovf(o_arr[2]),
        .busy(b_arr[2]), .overflow(f_arr[2])
    );

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  idx;
        logic        last;
        logic        ovf;
    } exp_t;

    exp_t q[3][$];
    bit   sticky[3];
    int   checks = 0;
    int   errors = 0;

    // Reference model: instance 0 is 32-bit wrap, 1 is 8-bit wrap, 2 is 8-bit saturate.
    task automatic push_model(input int w, input logic [31:0] s0, input logic [31:0] s1,
                              input int n);
        longint mask, a, b, sum;
        bit ta, tb, c, sat;
        exp_t e;
        int width;
        width = (w == 0) ? 32 : 8;
        sat   = (w == 2);
        mask  = (longint'(1) << width) - 1;
        a = longint'(s0) & mask;
        b = longint'(s1) & mask;
        ta = 1'b0;
        tb = 1'b0;
        for (int k = 0; k < n; k++) begin
            e.data = a[31:0];
            e.idx  = k[7:0];
            e.last = (k == n - 1);
            e.ovf  = ta;
            q[w].push_back(e);
            sum = a + b;
            c = (sum > mask);
            if (c) sum = sat ? mask : (sum & mask);
            a  = b;
            ta = tb;
            b  = sum;
            tb = c;
        end
    endtask

    task automatic start_run(input logic [31:0] s0, input logic [31:0] s1, input int n);
        @(posedge clk);
        #1;
        seed0   = s0;
        seed1   = s1;
        n_terms = n[7:0];
        start   = 1'b1;
        if (n != 0) begin
            for (int w = 0; w < 3; w++) begin
                push_model(w, s0, s1, n);
                sticky[w] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Streams the expected terms out of all instances; mode 1 toggles ready 1,0,0.
    // start_at >= 0 pulses a spurious start at that cycle of the run.
    task automatic drain(input int mode, input int start_at, input string name);
        int   cyc;
        bit   done;
        exp_t e;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start     = (cyc == start_at);
            seed0     = 32'h55;
            seed1     = 32'h77;
            n_terms   = 8'd3;
            @(negedge clk);
            for (int w = 0; w < 3; w++) begin
                if (q[w].size() != 0) begin
                    checks++;
                    if (v_arr[w] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s dut%0d valid got %b need 1 (cyc %0d)", name, w, v_arr[w], cyc);
                    end else begin
                        e = q[w][0];
                        if (e.ovf) sticky[w] = 1'b1;
                        checks++;
                        if ({d_arr[w], i_arr[w], l_arr[w], o_arr[w]} !== {e.data, e.idx, e.last, e.ovf}) begin
                            errors++;
                            $display("FAIL %s dut%0d term got data=%0d idx=%0d last=%b ovf=%b need data=%0d idx=%0d last=%b ovf=%b",
                                     name, w, d_arr[w], i_arr[w], l_arr[w], o_arr[w], e.data, e.idx, e.last, e.ovf);
                        end
                        checks++;
                        if (f_arr[w] !== sticky[w]) begin
                            errors++;
                            $display("FAIL %s dut%0d overflow got %b need %b at idx %0d", name, w, f_arr[w], sticky[w], e.idx);
                        end
                        if (out_ready) begin
                            $display("%s dut%0d idx=%0d data=%0d last=%b ovf=%b", name, w, e.idx, e.data, e.last, e.ovf);
                            void'(q[w].pop_front());
                        end
                    end
                end else if (v_arr[w] !== 1'b0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s dut%0d extra term got data=%0d idx=%0d need none", name, w, d_arr[w], i_arr[w]);
                end
            end
            done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got %0d/%0d/%0d left need 0", name, q[0].size(), q[1].size(), q[2].size());
            for (int w = 0; w < 3; w++) q[w].delete();
        end
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({v_arr[w], b_arr[w]} !== 2'b00) begin
                errors++;
                $display("FAIL %s dut%0d after-run valid/busy got %b%b need 00", name, w, v_arr[w], b_arr[w]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({v_arr[w], d_arr[w], i_arr[w], l_arr[w], o_arr[w], b_arr[w], f_arr[w]} !== '0) begin
                errors++;
                $display("FAIL reset dut%0d outputs got v=%b d=%0d i=%0d l=%b o=%b b=%b f=%b need all 0",
                         w, v_arr[w], d_arr[w], i_arr[w], l_arr[w], o_arr[w], b_arr[w], f_arr[w]);
            end
        end
        $display("reset done");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_run(32'd0, 32'd1, 10);
        drain(0, -1, "basic");
    endtask

    task automatic test_backpressure();
        start_run(32'd0, 32'd1, 10);
        drain(1, -1, "backpressure");
    endtask

    task automatic test_wrap_sat();
        start_run(32'd0, 32'd1, 16);
        drain(0, -1, "wrap_sat");
        for (int w = 1; w < 3; w++) begin
            checks++;
            if (f_arr[w] !== 1'b1) begin
                errors++;
                $display("FAIL wrap_sat dut%0d overflow after run got %b need 1", w, f_arr[w]);
            end
        end
    endtask

    task automatic test_zero_terms();
        start_run(32'd7, 32'd9, 0);
        @(negedge clk);
        $display("zero_terms start issued");
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({v_arr[w], b_arr[w], f_arr[w]} !== {2'b00, (w != 0)}) begin
                errors++;
                $display("FAIL zero_terms dut%0d valid/busy/overflow got %b%b%b need 00%b",
                         w, v_arr[w], b_arr[w], f_arr[w], (w != 0));
            end
        end
    endtask

    task automatic test_single();
        start_run(32'd2, 32'd1, 1);
        drain(0, -1, "single");
    endtask

    task automatic test_start_ignored();
        start_run(32'd2, 32'd1, 8);
        drain(1, 4, "start_ignored");
    endtask

    task automatic test_reset_midrun();
        bit hit;
        hit = 1'b0;
        start_run(32'd0, 32'd1, 10);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (v_arr[0] && i_arr[0] == 8'd4) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_midrun idx4 not reached got idx=%0d need 4", i_arr[0]);
        end
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (d_arr[w] !== 32'd3) begin
                errors++;
                $display("FAIL reset_midrun dut%0d idx4 data got %0d need 3", w, d_arr[w]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({v_arr[w], d_arr[w], i_arr[w], l_arr[w], o_arr[w], b_arr[w], f_arr[w]} !== '0) begin
                errors++;
                $display("FAIL reset_midrun dut%0d outputs got v=%b d=%0d i=%0d b=%b need all 0",
                         w, v_arr[w], d_arr[w], i_arr[w], b_arr[w]);
            end
            q[w].delete();
        end
        $display("reset_midrun done");
        rst = 1'b0;
    endtask

`ifdef FIB_SEQ_ABORT_EN
    task automatic test_abort();
        bit hit;
        hit = 1'b0;
        start_run(32'd200, 32'd100, 10);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (v_arr[1] && i_arr[1] == 8'd3) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort idx3 not reached got idx=%0d need 3", i_arr[1]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({v_arr[w], l_arr[w], b_arr[w], f_arr[w]} !== {3'b000, (w != 0)}) begin
                errors++;
                $display("FAIL abort dut%0d valid/last/busy/overflow got %b%b%b%b need 000%b",
                         w, v_arr[w], l_arr[w], b_arr[w], f_arr[w], (w != 0));
            end
            checks++;
            if (i_arr[w] !== 8'd3) begin
                errors++;
                $display("FAIL abort dut%0d idx after abort got %0d need 3", w, i_arr[w]);
            end
            q[w].delete();
        end
        $display("abort done");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        seed0     = '0;
        seed1     = '0;
        n_terms   = '0;
        out_ready = 1'b0;
`ifdef FIB_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_sat();
        test_zero_terms();
        test_single();
        test_start_ignored();
        test_reset_midrun();
`ifdef FIB_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
